// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap/return sequencer.
// Emits a one-cycle registered redirect to mtvec (trap) or mepc (mret).
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] pc_mem,
  input  logic        is_mret,
  input  logic        csr_wr,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic        epc_taken,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_TRAP = 2'd1, S_RET = 2'd2} state_e;

  state_e      state_q;
  logic        epc_taken_q;
  logic [31:0] epc_q;
  logic        tirq_meta_q, tirq_q, eirq_meta_q, eirq_q;
  logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic        mtie_q, mtie_d, meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;

  logic [31:0] mstatus_s, mie_s, mip_s, wval_s;
  logic        run_s, irq_ext_s, irq_tmr_s, irq_go_s, mret_go_s, wr_en_s;

  assign mstatus_s = {24'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};
  assign mie_s     = {20'd0, meie_q, 3'd0, mtie_q, 7'd0};
  assign mip_s     = {20'd0, eirq_q, 3'd0, tirq_q, 7'd0};

  assign run_s     = (state_q == S_RUN);
  assign irq_ext_s = eirq_q & meie_q;
  assign irq_tmr_s = tirq_q & mtie_q;
  assign irq_go_s  = run_s & instr_valid & st_mie_q & (irq_ext_s | irq_tmr_s);
  assign mret_go_s = run_s & is_mret & instr_valid & ~irq_go_s;
  // A trap or a flushed (holdoff) instruction must not commit its CSR write
  assign wr_en_s   = run_s & csr_wr & (csr_op != 2'b00) & ~irq_go_s;

  // CSR read mux
  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = mstatus_s;
      12'h304: csr_rdata = mie_s;
      12'h305: csr_rdata = mtvec_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h344: csr_rdata = mip_s;
      12'hB00: csr_rdata = mcycle_q[31:0];
      12'hB80: csr_rdata = mcycle_q[63:32];
      default: csr_rdata = 32'd0;
    endcase
  end

  // Write operand after applying the RW/RS/RC operation to the current value
  always_comb begin
    case (csr_op)
      2'b01:   wval_s = csr_wdata;
      2'b10:   wval_s = csr_rdata | csr_wdata;
      2'b11:   wval_s = csr_rdata & ~csr_wdata;
      default: wval_s = csr_rdata;
    endcase
  end

  // CSR next-state: write first, then trap/return side effects override it
  always_comb begin
    st_mie_d  = st_mie_q;
    st_mpie_d = st_mpie_q;
    mtie_d    = mtie_q;
    meie_d    = meie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mcycle_d  = mcycle_q + 64'd1;
    if (wr_en_s) begin
      case (csr_addr)
        12'h300: begin
          st_mie_d  = wval_s[3];
          st_mpie_d = wval_s[7];
        end
        12'h304: begin
          mtie_d = wval_s[7];
          meie_d = wval_s[11];
        end
        12'h305: mtvec_d  = wval_s & 32'hFFFF_FFFC;
        12'h341: mepc_d   = wval_s & 32'hFFFF_FFFC;
        12'h342: mcause_d = wval_s;
        12'hB00: mcycle_d = {mcycle_q[63:32], wval_s};
        12'hB80: mcycle_d = {wval_s, mcycle_q[31:0]};
        default: mcycle_d = mcycle_q + 64'd1;
      endcase
    end else begin
      mcycle_d = mcycle_q + 64'd1;
    end
    if (irq_go_s) begin
      mepc_d    = pc_mem & 32'hFFFF_FFFC;
      mcause_d  = irq_ext_s ? 32'h8000_000B : 32'h8000_0007;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (mret_go_s) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else begin
      mepc_d = mepc_d;
    end
  end

  // CSR storage and irq synchronisers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tirq_meta_q <= 1'b0;
      tirq_q      <= 1'b0;
      eirq_meta_q <= 1'b0;
      eirq_q      <= 1'b0;
      st_mie_q    <= 1'b0;
      st_mpie_q   <= 1'b0;
      mtie_q      <= 1'b0;
      meie_q      <= 1'b0;
      mtvec_q     <= MTVEC_RESET & 32'hFFFF_FFFC;
      mepc_q      <= 32'd0;
      mcause_q    <= 32'd0;
      mcycle_q    <= 64'd0;
    end else begin
      tirq_meta_q <= timer_irq;
      tirq_q      <= tirq_meta_q;
      eirq_meta_q <= ext_irq;
      eirq_q      <= eirq_meta_q;
      st_mie_q    <= st_mie_d;
      st_mpie_q   <= st_mpie_d;
      mtie_q      <= mtie_d;
      meie_q      <= meie_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mcycle_q    <= mcycle_d;
    end
  end

  // Trap sequencer with registered redirect outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      epc_taken_q <= 1'b0;
      epc_q       <= 32'd0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (irq_go_s) begin
            state_q     <= S_TRAP;
            epc_taken_q <= 1'b1;
            epc_q       <= mtvec_q;
          end else if (mret_go_s) begin
            state_q     <= S_RET;
            epc_taken_q <= 1'b1;
            epc_q       <= mepc_q;
          end else begin
            state_q     <= S_RUN;
            epc_taken_q <= 1'b0;
            epc_q       <= 32'd0;
          end
        end
        default: begin
          state_q     <= S_RUN;
          epc_taken_q <= 1'b0;
          epc_q       <= 32'd0;
        end
      endcase
    end
  end

  assign epc_taken = epc_taken_q;
  assign epc       = epc_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed self-checking bench for csr_trap_ctrl.
module tb_csr_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] pc_mem;
  logic        is_mret;
  logic        csr_wr;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        timer_irq;
  logic        ext_irq;
  logic        epc_taken;
  logic [31:0] epc;

  int n_tests = 0;
  int n_fail  = 0;

  csr_trap_ctrl #(.MTVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc_mem(pc_mem),
    .is_mret(is_mret), .csr_wr(csr_wr), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .timer_irq(timer_irq),
    .ext_irq(ext_irq), .epc_taken(epc_taken), .epc(epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = d;
    csr_wr    = 1'b1;
    tick();
    csr_wr = 1'b0;
    csr_op = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; pc_mem = 32'd0; is_mret = 1'b0;
    csr_wr = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = 32'd0;
    timer_irq = 1'b0; ext_irq = 1'b0;

    // Reset defaults
    #23;
    check("rst_taken", {31'd0, epc_taken}, 32'd0);
    rst_n = 1'b1;
    tick();
    rd(12'h305, 32'h0000_0100, "rst_mtvec");
    rd(12'h300, 32'h0000_0000, "rst_mstatus");
    check("rst_taken2", {31'd0, epc_taken}, 32'd0);

    // Timer trap
    wr(12'h300, 2'b01, 32'h0000_0008);
    wr(12'h304, 2'b01, 32'h0000_0080);
    wr(12'h305, 2'b01, 32'h0000_0200);
    pc_mem = 32'h0000_1234; instr_valid = 1'b1; timer_irq = 1'b1;
    tick();
    check("tmr_k", {31'd0, epc_taken}, 32'd0);
    tick();
    check("tmr_k1", {31'd0, epc_taken}, 32'd0);
    rd(12'h344, 32'h0000_0080, "tmr_mip");
    tick();
    check("tmr_taken", {31'd0, epc_taken}, 32'd1);
    check("tmr_epc", epc, 32'h0000_0200);
    tick();
    check("tmr_once", {31'd0, epc_taken}, 32'd0);
    timer_irq = 1'b0; instr_valid = 1'b0;
    rd(12'h341, 32'h0000_1234, "tmr_mepc");
    rd(12'h342, 32'h8000_0007, "tmr_mcause");
    rd(12'h300, 32'h0000_0080, "tmr_mstatus");
    tick(); tick();

    // mret return
    is_mret = 1'b1; instr_valid = 1'b1; pc_mem = 32'h0000_2000;
    tick();
    check("ret_taken", {31'd0, epc_taken}, 32'd1);
    check("ret_epc", epc, 32'h0000_1234);
    is_mret = 1'b0; instr_valid = 1'b0;
    tick();
    check("ret_once", {31'd0, epc_taken}, 32'd0);
    rd(12'h300, 32'h0000_0088, "ret_mstatus");

    // Priority and holdoff
    wr(12'h304, 2'b01, 32'h0000_0880);
    pc_mem = 32'h0000_3000; instr_valid = 1'b1; timer_irq = 1'b1; ext_irq = 1'b1;
    tick(); tick();
    rd(12'h344, 32'h0000_0880, "pri_mip");
    tick();
    check("pri_taken", {31'd0, epc_taken}, 32'd1);
    check("pri_epc", epc, 32'h0000_0200);
    wr(12'h305, 2'b01, 32'h0000_0400);
    check("pri_no2nd", {31'd0, epc_taken}, 32'd0);
    tick();
    check("pri_no3rd", {31'd0, epc_taken}, 32'd0);
    rd(12'h342, 32'h8000_000B, "pri_mcause");
    rd(12'h305, 32'h0000_0200, "hold_mtvec");
    rd(12'h341, 32'h0000_3000, "pri_mepc");
    timer_irq = 1'b0; ext_irq = 1'b0; instr_valid = 1'b0;
    tick(); tick();

    // mret together with an enabled irq: trap wins
    is_mret = 1'b1; instr_valid = 1'b1;
    tick();
    check("ret2_epc", epc, 32'h0000_3000);
    is_mret = 1'b0; instr_valid = 1'b0;
    timer_irq = 1'b1;
    tick(); tick(); tick();
    is_mret = 1'b1; instr_valid = 1'b1; pc_mem = 32'h0000_4000;
    tick();
    check("mi_taken", {31'd0, epc_taken}, 32'd1);
    check("mi_epc", epc, 32'h0000_0200);
    is_mret = 1'b0; instr_valid = 1'b0; timer_irq = 1'b0;
    rd(12'h341, 32'h0000_4000, "mi_mepc");
    rd(12'h342, 32'h8000_0007, "mi_mcause");
    rd(12'h300, 32'h0000_0080, "mi_mstatus");
    tick(); tick();

    // CSR operations
    wr(12'h300, 2'b01, 32'h0000_0000);
    wr(12'h300, 2'b10, 32'h0000_0008);
    rd(12'h300, 32'h0000_0008, "rs_mstatus");
    wr(12'h300, 2'b11, 32'h0000_0008);
    rd(12'h300, 32'h0000_0000, "rc_mstatus");
    wr(12'h341, 2'b01, 32'h0000_1003);
    rd(12'h341, 32'h0000_1000, "mepc_align");
    wr(12'h344, 2'b01, 32'hFFFF_FFFF);
    rd(12'h344, 32'h0000_0000, "mip_ro");
    rd(12'h123, 32'h0000_0000, "unmapped");

    // mret with a mstatus write: restore overrides the write
    is_mret = 1'b1; instr_valid = 1'b1;
    wr(12'h300, 2'b01, 32'h0000_0008);
    check("mw_epc", epc, 32'h0000_1000);
    is_mret = 1'b0; instr_valid = 1'b0;
    rd(12'h300, 32'h0000_0080, "mw_mstatus");
    tick();

    // mcycle wrap
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "cyc_lo_hold");
    tick();
    rd(12'hB00, 32'h0000_0000, "cyc_lo_wrap");
    rd(12'hB80, 32'h0000_0000, "cyc_hi_wrap");

    // Asynchronous reset during TRAP
    wr(12'h300, 2'b01, 32'h0000_0008);
    pc_mem = 32'h0000_5000; instr_valid = 1'b1; timer_irq = 1'b1;
    tick(); tick(); tick();
    check("ar_taken", {31'd0, epc_taken}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_drop", {31'd0, epc_taken}, 32'd0);
    check("ar_epc", epc, 32'd0);
    rd(12'h305, 32'h0000_0100, "ar_mtvec");
    rd(12'h300, 32'h0000_0000, "ar_mstatus");
    timer_irq = 1'b0; instr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_after", {31'd0, epc_taken}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
